wavegen: RTL and testbench
==========================

WAVEGEN -- requirements
Module: wavegen

Interface
REQ-001 SHALL have parameter PHASE_W, default 32: phase accumulator width, PHASE_W >= OUT_W+2.
REQ-002 SHALL have parameter OUT_W, default 24: sample width, two's complement.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  generator enable.
REQ-006 SHALL have port inc  input  PHASE_W  phase increment per clk (frequency = inc*f_clk/2^PHASE_W).
REQ-007 SHALL have port mode  input  2  0 square, 1 pulse, 2 sawtooth, 3 triangle.
REQ-008 SHALL have port duty  input  PHASE_W  pulse high threshold, mode 1 only.
REQ-009 SHALL have port amp  input  OUT_W  unsigned amplitude scale, unlatched.
REQ-010 SHALL have port tone  output  OUT_W  signed sample, registered.
REQ-011 SHALL have port sync  output  1  one-cycle pulse marking the first sample of each period.

Function
REQ-012 SHALL keep shadow registers inc_l, mode_l, duty_l, loaded from inputs every clk while en=0 and on the clk where phase+inc_l carries out of PHASE_W bits (wrap); held otherwise.
REQ-013 SHALL update phase <= en ? phase+inc_l (mod 2^PHASE_W) : 0.
REQ-014 SHALL compute stage-1 raw sample r <= en ? shape(phase, mode_l) : 0, with MAX = 2^(OUT_W-1)-1.
REQ-015 SHALL give square r = phase[PHASE_W-1]==0 ? +MAX : -MAX.
REQ-016 SHALL give pulse r = phase < duty_l (unsigned) ? +MAX : -MAX; duty_l=0 gives constant -MAX.
REQ-017 SHALL give sawtooth r = phase[PHASE_W-1 -: OUT_W] with MSB inverted.
REQ-018 SHALL give triangle r = (phase[PHASE_W-2 -: OUT_W] XOR all-bits phase[PHASE_W-1]) with MSB inverted.
REQ-019 SHALL compute stage-2 tone <= v1 ? (r * signed{0,amp}) >>> OUT_W, truncated to OUT_W : 0, v1 = en delayed one clk; floor rounding.
REQ-020 SHALL assert sync <= v1 AND (stage-1 sample came from phase 0 or a wrap), aligned with tone.
REQ-021 SHALL give latency 2 clks from the phase register to tone; the first enabled sample is phase 0.
REQ-022 SHALL drive tone=0 and sync=0 by the second clk after en falls; en toggle mid-period restarts at phase 0.
REQ-023 SHALL apply inc=0 as DC output of the current phase, with no wrap and no sync.

Reset
REQ-024 SHALL, on rst_n=0, asynchronously clear phase, r, v1, tone, sync, inc_l, mode_l and duty_l to 0.
REQ-025 SHALL resume on the first clk after rst_n deasserts, per REQ-012..013.

Configuration
REQ-026 SHALL implement triangle mode only when macro WAVEGEN_TRI_EN is defined; otherwise mode 3 yields r=0 (silence), and all other modes are unchanged.

Structure
REQ-027 SHALL place mode encodings (MODE_SQUARE..MODE_TRIANGLE) and the MAX constant function in shared package wavegen_pkg.
REQ-028 SHALL isolate the shape selection (REQ-015..018) in combinational sub-module wavegen_shape; accumulator, latching and scaling stay in wavegen.

Verification (PHASE_W=10, OUT_W=8)
REQ-029 SHALL check: reset, then en=1, mode=0, inc=16, amp=255 -> period 64 clks, tone +126 for 32 samples then -127 for 32, sync every 64 clks.
REQ-030 SHALL check: mode=1, duty=256, inc=16 -> +126 for 16 samples, -127 for 48.
REQ-031 SHALL check: mode=2, inc=4, amp=255 -> tone ramps -128..+126 in steps near 1, sync at the -128 sample.
REQ-032 SHALL check: mode 3 with WAVEGEN_TRI_EN defined gives a symmetric triangle with peaks near +-127; without the macro, tone stays 0.
REQ-033 SHALL check: inc changed 16->32 mid-period -> the old period completes (64 clks) before the new 32-clk period starts; no glitch.
REQ-034 SHALL check: en dropped mid-period, or rst_n pulsed asynchronously between edges -> tone=0 within 2 clks (immediately for reset); re-enable restarts at phase 0 with sync.

Source files
------------

// File: rtl/wavegen_pkg.sv
// wavegen_pkg: shared mode encodings and sample-limit helper for the wavegen block.
package wavegen_pkg;

  typedef enum logic [1:0] {
    MODE_SQUARE   = 2'd0,
    MODE_PULSE    = 2'd1,
    MODE_SAWTOOTH = 2'd2,
    MODE_TRIANGLE = 2'd3
  } mode_e;

  // Largest positive two's-complement sample for an out_w-bit output.
  function automatic int unsigned max_val(input int unsigned out_w);
    return (32'd1 << (out_w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/wavegen_shape.sv
// wavegen_shape: combinational waveform shaper, maps phase + mode to a raw full-scale sample.
// Triangle mode is built only when WAVEGEN_TRI_EN is defined; otherwise mode 3 is silent.
module wavegen_shape
  import wavegen_pkg::*;
#(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned OUT_W   = 24
) (
  input  logic [PHASE_W-1:0] phase,
  input  logic [1:0]         mode,
  input  logic [PHASE_W-1:0] duty,
  output logic [OUT_W-1:0]   r
);

  localparam logic [OUT_W-1:0] MaxPos = OUT_W'(max_val(OUT_W));
  localparam logic [OUT_W-1:0] MaxNeg = ~MaxPos + 1'b1;

  logic [OUT_W-1:0] saw_v;
  assign saw_v = phase[PHASE_W-1 -: OUT_W];

`ifdef WAVEGEN_TRI_EN
  // Fold the second half of the period back down so the ramp runs up then down.
  logic [OUT_W-1:0] tri_v;
  assign tri_v = phase[PHASE_W-2 -: OUT_W] ^ {OUT_W{phase[PHASE_W-1]}};
`endif

  // Shape select; MSB inversion turns an offset-binary ramp into two's complement.
  always_comb begin
    r = '0;
    case (mode)
      MODE_SQUARE:   r = phase[PHASE_W-1] ? MaxNeg : MaxPos;
      MODE_PULSE:    r = (phase < duty) ? MaxPos : MaxNeg;
      MODE_SAWTOOTH: r = {~saw_v[OUT_W-1], saw_v[OUT_W-2:0]};
      MODE_TRIANGLE: begin
`ifdef WAVEGEN_TRI_EN
        r = {~tri_v[OUT_W-1], tri_v[OUT_W-2:0]};
`else
        r = '0;
`endif
      end
      default:       r = '0;
    endcase
  end

endmodule

// File: rtl/wavegen.sv
// wavegen: phase-accumulator waveform generator (square/pulse/sawtooth/triangle).
// Two-stage pipeline: phase -> raw sample r -> amplitude-scaled tone.
// Triangle mode requires macro WAVEGEN_TRI_EN (see wavegen_shape).
module wavegen
  import wavegen_pkg::*;
#(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned OUT_W   = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [PHASE_W-1:0] inc,
  input  logic [1:0]         mode,
  input  logic [PHASE_W-1:0] duty,
  input  logic [OUT_W-1:0]   amp,
  output logic [OUT_W-1:0]   tone,
  output logic               sync
);

  logic [PHASE_W-1:0] inc_l, duty_l, phase;
  logic [1:0]         mode_l;
  logic [PHASE_W:0]   sum;
  logic               wrap, load;
  logic               first_q;   // current phase value starts a period
  logic [OUT_W-1:0]   shape_r, r;
  logic               r_first, v1;
  logic signed [2*OUT_W:0] prod;
  logic               unused_prod;

  assign sum  = {1'b0, phase} + {1'b0, inc_l};
  assign wrap = sum[PHASE_W];
  // Settings only change while idle or at a period boundary, so a period never glitches.
  assign load = ~en | wrap;

  wavegen_shape #(
    .PHASE_W (PHASE_W),
    .OUT_W   (OUT_W)
  ) u_shape (
    .phase (phase),
    .mode  (mode_l),
    .duty  (duty_l),
    .r     (shape_r)
  );

  // Amplitude is an unsigned factor; a zero-extended operand keeps the product signed.
  assign prod        = $signed(r) * $signed({1'b0, amp});
  assign unused_prod = ^{prod[2*OUT_W], prod[OUT_W-1:0]};

  // Shadow settings register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_l  <= '0;
      mode_l <= '0;
      duty_l <= '0;
    end else if (load) begin
      inc_l  <= inc;
      mode_l <= mode;
      duty_l <= duty;
    end
  end

  // Phase accumulator and stage-1 raw sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= '0;
      first_q <= 1'b1;
      r       <= '0;
      r_first <= 1'b0;
      v1      <= 1'b0;
    end else begin
      phase   <= en ? sum[PHASE_W-1:0] : '0;
      first_q <= en ? wrap : 1'b1;
      r       <= en ? shape_r : '0;
      r_first <= en & first_q;
      v1      <= en;
    end
  end

  // Stage-2 scaled output; arithmetic shift by OUT_W floors toward -inf.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone <= '0;
      sync <= 1'b0;
    end else begin
      tone <= v1 ? prod[2*OUT_W-1 -: OUT_W] : '0;
      sync <= v1 & r_first;
    end
  end

endmodule

// File: tb/tb_wavegen.sv
// tb_wavegen: directed, table-driven bench for wavegen at PHASE_W=10, OUT_W=8.
module tb_wavegen;

  localparam int unsigned PW = 10;
  localparam int unsigned OW = 8;

  logic          clk = 1'b0;
  logic          rst_n, en, sync;
  logic [PW-1:0] inc, duty;
  logic [1:0]    mode;
  logic [OW-1:0] amp, tone;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wavegen #(
    .PHASE_W (PW),
    .OUT_W   (OW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .inc   (inc),
    .mode  (mode),
    .duty  (duty),
    .amp   (amp),
    .tone  (tone),
    .sync  (sync)
  );

  typedef struct {
    int m;
    int i;
    int d;
    int a;
    int idx;
    int exp_tone;
    int exp_sync;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int m, int i, int d, int a, int idx, int t, int s);
    vec_t v;
    v.m = m; v.i = i; v.d = d; v.a = a; v.idx = idx; v.exp_tone = t; v.exp_sync = s;
    return v;
  endfunction

  // Reference raw sample for a phase value (MAX = 127).
  function automatic int raw_model(int m, int ph, int d);
    case (m)
      0:       return (ph < 512) ? 127 : -127;
      1:       return (ph < d) ? 127 : -127;
      2:       return (ph / 4) - 128;
`ifdef WAVEGEN_TRI_EN
      default: return ((ph < 512) ? (ph / 2) : ((1023 - ph) / 2)) - 128;
`else
      default: return 0;
`endif
    endcase
  endfunction

  function automatic int scale_model(int r, int a);
    return int'($floor(real'(r * a) / 256.0));
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    @(negedge clk);
  endtask

  // Idle two clocks with new settings, then raise en; cyc(n+2) afterwards shows sample n.
  task automatic restart(input int m, input int i, input int d, input int a);
    @(negedge clk);
    en   = 1'b0;
    mode = 2'(m);
    inc  = PW'(i);
    duty = PW'(d);
    amp  = OW'(a);
    repeat (2) @(negedge clk);
    en = 1'b1;
  endtask

  function automatic int stone();
    return int'($signed(tone));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ph;
    int t_tri0, t_tri127, t_tri128;
    int sw_m[4]   = '{0, 1, 2, 3};
    int sw_i[4]   = '{16, 16, 4, 4};
    int sw_d[4]   = '{0, 256, 0, 0};
    int sw_len[4] = '{128, 64, 257, 257};

`ifdef WAVEGEN_TRI_EN
    t_tri0 = -128; t_tri127 = 125; t_tri128 = 126;
`else
    t_tri0 = 0; t_tri127 = 0; t_tri128 = 0;
`endif

    vecs.push_back(mk(0, 16, 0,   255, 0,   126,  1));
    vecs.push_back(mk(0, 16, 0,   255, 31,  126,  0));
    vecs.push_back(mk(0, 16, 0,   255, 32,  -127, 0));
    vecs.push_back(mk(0, 16, 0,   255, 64,  126,  1));
    vecs.push_back(mk(1, 16, 256, 255, 15,  126,  0));
    vecs.push_back(mk(1, 16, 256, 255, 16,  -127, 0));
    vecs.push_back(mk(1, 16, 256, 255, 64,  126,  1));
    vecs.push_back(mk(1, 16, 0,   255, 0,   -127, 1));
    vecs.push_back(mk(1, 16, 0,   255, 40,  -127, 0));
    vecs.push_back(mk(2, 4,  0,   255, 0,   -128, 1));
    vecs.push_back(mk(2, 4,  0,   255, 128, 0,    0));
    vecs.push_back(mk(2, 4,  0,   255, 130, 1,    0));
    vecs.push_back(mk(2, 4,  0,   255, 255, 126,  0));
    vecs.push_back(mk(2, 4,  0,   255, 256, -128, 1));
    vecs.push_back(mk(0, 16, 0,   128, 0,   63,   1));
    vecs.push_back(mk(0, 16, 0,   128, 32,  -64,  0));
    vecs.push_back(mk(2, 4,  0,   128, 0,   -64,  1));
    vecs.push_back(mk(0, 16, 0,   0,   5,   0,    0));
    vecs.push_back(mk(0, 0,  0,   255, 0,   126,  1));
    vecs.push_back(mk(0, 0,  0,   255, 5,   126,  0));
    vecs.push_back(mk(3, 4,  0,   255, 0,   t_tri0,   1));
    vecs.push_back(mk(3, 4,  0,   255, 127, t_tri127, 0));
    vecs.push_back(mk(3, 4,  0,   255, 128, t_tri128, 0));

    // Reset state.
    rst_n = 1'b0; en = 1'b0; mode = 2'd0; inc = PW'(16); duty = '0; amp = OW'(255);
    #12;
    check("reset_tone", stone(), 0);
    check("reset_sync", int'(sync), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(3);
    check("idle_tone", stone(), 0);

    // Hand-computed spot vectors.
    foreach (vecs[k]) begin
      restart(vecs[k].m, vecs[k].i, vecs[k].d, vecs[k].a);
      cyc(vecs[k].idx + 2);
      check($sformatf("vec%0d_tone", k), stone(), vecs[k].exp_tone);
      check($sformatf("vec%0d_sync", k), int'(sync), vecs[k].exp_sync);
    end

    // Full-period sweeps per mode.
    for (int s = 0; s < 4; s++) begin
      restart(sw_m[s], sw_i[s], sw_d[s], 255);
      cyc(2);
      for (int n = 0; n < sw_len[s]; n++) begin
        ph = (n * sw_i[s]) % 1024;
        check($sformatf("sweep%0d_n%0d_tone", s, n), stone(),
              scale_model(raw_model(sw_m[s], ph, sw_d[s]), 255));
        check($sformatf("sweep%0d_n%0d_sync", s, n), int'(sync), (ph == 0) ? 1 : 0);
        cyc(1);
      end
    end

    // inc change mid-period: old 64-sample period completes, then 32-sample periods.
    restart(0, 16, 0, 255);
    cyc(2);
    for (int n = 0; n < 128; n++) begin
      ph = (n < 64) ? (n * 16) : (((n - 64) * 32) % 1024);
      check($sformatf("incchg_n%0d_tone", n), stone(), scale_model(raw_model(0, ph, 0), 255));
      check($sformatf("incchg_n%0d_sync", n), int'(sync), (ph == 0) ? 1 : 0);
      if (n == 10) inc = PW'(32);
      cyc(1);
    end

    // en dropped mid-period: silent within two clocks, re-enable restarts at phase 0.
    restart(0, 16, 0, 255);
    cyc(12);
    check("endrop_pre_tone", stone(), 126);
    en = 1'b0;
    cyc(2);
    check("endrop_tone", stone(), 0);
    check("endrop_sync", int'(sync), 0);
    en = 1'b1;
    cyc(2);
    check("reen_tone", stone(), 126);
    check("reen_sync", int'(sync), 1);
    cyc(32);
    check("reen_half_tone", stone(), -127);
    check("reen_half_sync", int'(sync), 0);

    // Asynchronous reset between edges clears outputs immediately.
    restart(0, 16, 0, 255);
    cyc(22);
    check("arst_pre_tone", stone(), 126);
    #2;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    check("arst_tone", stone(), 0);
    check("arst_sync", int'(sync), 0);
    @(negedge clk);
    rst_n = 1'b1;
    restart(0, 16, 0, 255);
    cyc(2);
    check("arst_restart_tone", stone(), 126);
    check("arst_restart_sync", int'(sync), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
